// File: rtl/modn_updown_counter_chain.sv
// Cascaded modulo-MOD up/down counter of DIGITS digits with lookahead carry/borrow,
// synchronous clamped load, saturate mode, terminal-count flag and registered wrap pulse.
module modn_updown_counter_chain #(
  parameter int MOD    = 10,
  parameter int DW     = 4,
  parameter int DIGITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic                 sat,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 wrap
);

  localparam logic [DW-1:0] MAX_VAL = DW'(MOD - 1);
  localparam logic [DW:0]   MOD_EXT = (DW + 1)'(MOD);

  logic [DW-1:0]     digit      [DIGITS];
  logic [DW-1:0]     next_digit [DIGITS];
  logic [DW-1:0]     load_digit [DIGITS];
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] carry_in;
  logic [DIGITS-1:0] borrow_in;

  // Per-digit terminal detection and load clamping.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      at_max[k]     = (digit[k] == MAX_VAL);
      at_zero[k]    = (digit[k] == '0);
      load_digit[k] = ({1'b0, load_val[k*DW +: DW]} >= MOD_EXT) ? MAX_VAL
                                                                : load_val[k*DW +: DW];
    end
  end

  // Lookahead enables: digit k steps when every lower digit sits at its terminal value.
  always_comb begin
    logic run_up;
    logic run_dn;
    run_up    = 1'b1;
    run_dn    = 1'b1;
    carry_in  = '0;
    borrow_in = '0;
    for (int k = 0; k < DIGITS; k++) begin
      carry_in[k]  = run_up;
      borrow_in[k] = run_dn;
      run_up       = run_up & at_max[k];
      run_dn       = run_dn & at_zero[k];
    end
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      next_digit[k] = digit[k];
      if (up_dn) begin
        if (carry_in[k])
          next_digit[k] = at_max[k] ? '0 : digit[k] + 1'b1;
      end else begin
        if (borrow_in[k])
          next_digit[k] = at_zero[k] ? MAX_VAL : digit[k] - 1'b1;
      end
    end
  end

  assign tc = up_dn ? (&at_max) : (&at_zero);

  always_comb begin
    count = '0;
    for (int k = 0; k < DIGITS; k++)
      count[k*DW +: DW] = digit[k];
  end

  // A full-chain rollover is exactly an enabled step taken while tc is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DIGITS; k++)
        digit[k] <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      for (int k = 0; k < DIGITS; k++)
        digit[k] <= load_digit[k];
      wrap <= 1'b0;
    end else if (en) begin
      if (tc && sat) begin
        wrap <= 1'b0;
      end else begin
        for (int k = 0; k < DIGITS; k++)
          digit[k] <= next_digit[k];
        wrap <= tc;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modn_updown_counter_chain.sv
// Directed self-checking bench for the 2-digit BCD configuration of modn_updown_counter_chain.
module tb_modn_updown_counter_chain;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       sat;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  modn_updown_counter_chain #(.MOD(10), .DW(4), .DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Sample 1 ns after the rising edge so outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b0; sat = 1'b0; load = 1'b0; load_val = 8'h00;
    #12;
    checks++;
    if (count !== 8'h00) begin errors++; $display("[TB] FAIL reset_count: got %h want 00", count); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap: got %b want 0", wrap); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("[TB] FAIL reset_tc_down: got %b want 1", tc); end
    up_dn = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc_up: got %b want 0", tc); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    en = 1'b1; up_dn = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      checks++;
      if (count !== bcd(i % 100)) begin
        errors++; $display("[TB] FAIL up_count step %0d: got %h want %h", i, count, bcd(i % 100));
      end
      checks++;
      if (wrap !== (i == 100)) begin
        errors++; $display("[TB] FAIL up_wrap step %0d: got %b want %b", i, wrap, (i == 100));
      end
      checks++;
      if (tc !== (i == 99)) begin
        errors++; $display("[TB] FAIL up_tc step %0d: got %b want %b", i, tc, (i == 99));
      end
    end
  endtask

  task automatic test_down_borrow();
    logic [7:0] exp_down [3];
    exp_down[0] = 8'h99; exp_down[1] = 8'h98; exp_down[2] = 8'h97;
    en = 1'b0; load = 1'b1; load_val = 8'h00;
    step();
    checks++;
    if (count !== 8'h00 || wrap !== 1'b0) begin
      errors++; $display("[TB] FAIL down_load: got %h/%b want 00/0", count, wrap);
    end
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== exp_down[i]) begin
        errors++; $display("[TB] FAIL down_count %0d: got %h want %h", i, count, exp_down[i]);
      end
      checks++;
      if (wrap !== (i == 0)) begin
        errors++; $display("[TB] FAIL down_wrap %0d: got %b want %b", i, wrap, (i == 0));
      end
    end
    load = 1'b1; load_val = 8'h91;
    step();
    load = 1'b0;
    step();
    checks++;
    if (count !== 8'h90) begin errors++; $display("[TB] FAIL down_90: got %h want 90", count); end
    step();
    checks++;
    if (count !== 8'h89) begin errors++; $display("[TB] FAIL down_borrow_89: got %h want 89", count); end
  endtask

  task automatic test_saturate();
    sat = 1'b1; up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'h97;
    step();
    checks++;
    if (count !== 8'h97) begin errors++; $display("[TB] FAIL sat_load: got %h want 97", count); end
    load = 1'b0;
    step();
    checks++;
    if (count !== 8'h98) begin errors++; $display("[TB] FAIL sat_98: got %h want 98", count); end
    step();
    checks++;
    if (count !== 8'h99 || tc !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_99: got %h tc=%b want 99 tc=1", count, tc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count !== 8'h99 || tc !== 1'b1 || wrap !== 1'b0) begin
        errors++; $display("[TB] FAIL sat_hold %0d: got %h tc=%b wrap=%b want 99 tc=1 wrap=0", i, count, tc, wrap);
      end
    end
    up_dn = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("[TB] FAIL sat_tc_dir: got %b want 0", tc); end
    step();
    checks++;
    if (count !== 8'h98 || wrap !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_leave: got %h/%b want 98/0", count, wrap);
    end
    sat = 1'b0;
  endtask

  task automatic test_load_clamp();
    up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'hCF;
    step();
    checks++;
    if (count !== 8'h99 || wrap !== 1'b0) begin
      errors++; $display("[TB] FAIL clamp_CF: got %h/%b want 99/0", count, wrap);
    end
    load_val = 8'h5A;
    step();
    checks++;
    if (count !== 8'h59) begin errors++; $display("[TB] FAIL clamp_5A: got %h want 59", count); end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'h42;
    step();
    load = 1'b0;
    checks++;
    if (count !== 8'h42) begin errors++; $display("[TB] FAIL ar_load: got %h want 42", count); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (count !== 8'h00 || wrap !== 1'b0) begin
      errors++; $display("[TB] FAIL ar_async: got %h/%b want 00/0", count, wrap);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (count !== 8'h01) begin errors++; $display("[TB] FAIL ar_first_step: got %h want 01", count); end
    load = 1'b1; load_val = 8'h99;
    step();
    load = 1'b0;
    step();
    checks++;
    if (count !== 8'h00 || wrap !== 1'b1) begin
      errors++; $display("[TB] FAIL ar_prewrap: got %h/%b want 00/1", count, wrap);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL ar_wrap_clear: got %b want 0", wrap); end
    #2 rst = 1'b0;
  endtask

  task automatic test_enable_toggle();
    logic       en_seq  [4];
    logic [7:0] exp_seq [4];
    en_seq[0] = 1'b1; en_seq[1] = 1'b0; en_seq[2] = 1'b1; en_seq[3] = 1'b0;
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h01; exp_seq[2] = 8'h02; exp_seq[3] = 8'h02;
    en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 8'h00;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = en_seq[i];
      step();
      checks++;
      if (count !== exp_seq[i] || wrap !== 1'b0) begin
        errors++; $display("[TB] FAIL en_toggle %0d: got %h/%b want %h/0", i, count, wrap, exp_seq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_saturate();
    test_load_clamp();
    test_async_reset();
    test_enable_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
